rr_grant_ctrl: RTL and testbench
================================

Name: rr_grant_ctrl

Overview:
- Round-robin arbiter/scheduler for the shared 3-to-8 select decoder.
- Eight requesters contend for one shared resource. The block picks one owner, holds it for a bounded time, and drives the registered 3-bit index that feeds the decoder input.
- grant_valid qualifies the decoded one-hot downstream.
- It sits between requesting units and the decoder/select fabric.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one owner may hold the grant. 0 means unlimited.
- HOLD_W, 8: width of the hold counter. MAX_HOLD must be at most 2^HOLD_W.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable. Low blocks new grants only.
- req  input  8  level request, one bit per requester. Held high while the requester wants or uses the resource.
- grant_idx  output  3  registered index of the current owner. Drives the decoder input.
- grant_valid  output  1  high while grant_idx names a valid owner.
- grant_onehot  output  8  one-hot of grant_idx when grant_valid=1, else 0. Registered, same timing as grant_idx.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - state=IDLE, grant_idx=0, grant_valid=0, grant_onehot=0, timeout=0, hold_cnt=0.
  - Priority pointer last=7, so the first search starts at requester 0.
- States: IDLE and GRANT.
- IDLE, at each edge with en=1 and req!=0:
  - Winner is the first set bit of req scanning last+1, last+2, … mod 8 (wrap 7→0).
  - Load grant_idx=winner, grant_onehot=1<<winner, grant_valid=1, last=winner, hold_cnt=0.
  - Next state is GRANT.
- IDLE with en=0 or req=0: stay in IDLE; outputs hold at no-grant values.
- Latency: req sampled high at edge N while IDLE → grant_valid high after edge N.
- GRANT, at each edge:
  - Release (checked first): if req[grant_idx]=0, then grant_valid=0, grant_onehot=0, state=IDLE. No timeout pulse.
  - Expiry: else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1, then grant_valid=0, grant_onehot=0, timeout=1 for one cycle, state=IDLE.
  - Otherwise: hold_cnt+1, grant unchanged.
- A grant lasts at most MAX_HOLD cycles.
- The cycle after any release or expiry is always a dead cycle (grant_valid=0). Minimum gap between grants is one cycle.
- grant_idx keeps the last owner value while grant_valid=0. Downstream must gate on grant_valid.
- en in GRANT: ignored. The current owner keeps the grant until release or expiry.
- Other req bits changing in GRANT: no effect until the next IDLE evaluation.
- Fairness: last is updated only on grant. After an owner finishes, that owner has lowest priority next round.
  - An expired owner still requesting is re-eligible, but only after all other active requesters in pointer order.
  - With all 8 requesting continuously, grant order is 0,1,…,7,0.
- Single requester: re-granted after each one-cycle gap. With continuous req and MAX_HOLD=M, pattern is M cycles on, 1 off.
- hold_cnt never wraps. With MAX_HOLD=0 it saturates at 2^HOLD_W-1 and the grant persists.
- timeout is low in all other cycles.
- Reset mid-grant: grant dropped immediately (asynchronous). Pointer returns to 7.
- Outputs are registered only. No combinational path from req to any output.

Test Plan:
- Reset, then req=8'h00 for 5 cycles → grant_valid=0, grant_onehot=0, timeout=0 throughout.
- Round-robin order:
  - Stimulus: req=8'hFF continuous, MAX_HOLD=4.
  - Grants 0,1,2,…,7,0 in order.
  - Each grant: 4 cycles grant_valid=1 with grant_onehot=1<<idx; timeout pulses on each expiry; 1 dead cycle between grants.
- Early release:
  - Stimulus: req=8'h24; owner 2 drops req[2] after 3 granted cycles.
  - grant_valid falls at next edge, no timeout, then 1 dead cycle.
  - Next grant goes to 5 (grant_idx=5, grant_onehot=8'h20).
- Wrap and fairness:
  - Stimulus: last owner 6; req=8'h41 (bits 0 and 6).
  - Next grant goes to 0, then 6, alternating.
- Enable gating:
  - Stimulus: en=0 in IDLE with req=8'h08.
  - No grant while en=0. Grant to 3 one edge after en rises.
  - en dropped mid-grant → grant continues until release.
- Asynchronous reset:
  - Stimulus: pulse rst_n low mid-grant, between clock edges.
  - grant_valid and grant_onehot go 0 without waiting for a clock edge.
  - With req=8'h81 after reset, first grant goes to 0.

Source files
------------

// File: rtl/rr_grant_ctrl_if.sv
// rtl/rr_grant_ctrl_if.sv - request/grant bundle between requesters and the arbiter
interface rr_grant_ctrl_if;
  logic       en;
  logic [7:0] req;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic [7:0] grant_onehot;
  logic       timeout;

  // Requester side drives enable and requests, observes the grant
  modport master (
    output en, req,
    input  grant_idx, grant_valid, grant_onehot, timeout
  );

  // Arbiter side consumes requests, drives the registered grant
  modport slave (
    input  en, req,
    output grant_idx, grant_valid, grant_onehot, timeout
  );
endinterface

// File: rtl/rr_grant_ctrl.sv
// rtl/rr_grant_ctrl.sv - round-robin arbiter driving the shared 3-to-8 select decoder
module rr_grant_ctrl #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input logic            clk,
  input logic            rst_n,
  rr_grant_ctrl_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  // Counter value on the final permitted cycle of a grant; unused when MAX_HOLD is 0
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        last_q, last_d;
  logic              valid_q, valid_d;
  logic [7:0]        onehot_q, onehot_d;
  logic              timeout_q, timeout_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [2:0]        winner;
  logic              winner_found;
  logic [2:0]        cand;

  // Search starts just after the previous owner so it gets lowest priority; k=8 wraps back to last
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    cand         = '0;
    for (int k = 1; k <= 8; k++) begin
      cand = last_q + 3'(k);
      if (!winner_found && bus.req[cand]) begin
        winner       = cand;
        winner_found = 1'b1;
      end
    end
  end

  // Next-state and next-output decisions; outputs are only ever taken from registers
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    valid_d   = valid_q;
    onehot_d  = onehot_q;
    timeout_d = 1'b0;
    hold_d    = hold_q;
    case (state_q)
      IDLE: begin
        if (bus.en && winner_found) begin
          state_d  = GRANT;
          idx_d    = winner;
          last_d   = winner;
          valid_d  = 1'b1;
          onehot_d = 8'b1 << winner;
          hold_d   = '0;
        end
      end
      GRANT: begin
        // Owner release wins over expiry so a voluntary drop never reports a timeout
        if (!bus.req[idx_q]) begin
          state_d  = IDLE;
          valid_d  = 1'b0;
          onehot_d = '0;
        end else if (MAX_HOLD != 0 && hold_q == HOLD_LAST) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          onehot_d  = '0;
          timeout_d = 1'b1;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        valid_d  = 1'b0;
        onehot_d = '0;
      end
    endcase
  end

  // State and output registers; reset drops any grant immediately and rewinds the pointer to 7
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      last_q    <= 3'd7;
      valid_q   <= 1'b0;
      onehot_q  <= '0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
      onehot_q  <= onehot_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.grant_idx    = idx_q;
  assign bus.grant_valid  = valid_q;
  assign bus.grant_onehot = onehot_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb/tb_rr_grant_ctrl.sv - scoreboard bench for rr_grant_ctrl
module tb_rr_grant_ctrl;
  localparam int MAXH = 4;

  logic clk;
  logic rst_n;

  rr_grant_ctrl_if bus ();

  rr_grant_ctrl #(.MAX_HOLD(MAXH), .HOLD_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       v;
    logic [2:0] idx;
    logic [7:0] oh;
    logic       to;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: who owns the resource and for how many cycles it has held it
  bit m_busy;
  int m_owner;
  int m_held;
  int m_last;
  bit m_to;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] req_v);
    n_tests++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req_v, $time);
    end
  endfunction

  function automatic void model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_held  = 0;
    m_last  = 7;
    m_to    = 0;
  endfunction

  // One clock edge of the reference, given the inputs present at that edge
  function automatic void model_edge(input logic e, input logic [7:0] r);
    int w;
    bit found;
    m_to = 0;
    if (!m_busy) begin
      if (e && r != 8'h00) begin
        found = 0;
        w = 0;
        for (int k = 1; k <= 8; k++) begin
          if (!found && r[(m_last + k) % 8]) begin
            w = (m_last + k) % 8;
            found = 1;
          end
        end
        m_busy  = 1;
        m_owner = w;
        m_held  = 1;
        m_last  = w;
      end
    end else if (!r[m_owner]) begin
      m_busy = 0;
    end else if (MAXH != 0 && m_held == MAXH) begin
      m_busy = 0;
      m_to   = 1;
    end else begin
      m_held++;
    end
  endfunction

  // Drive inputs shortly after a falling edge, record the expected post-edge outputs
  task automatic step(input logic e, input logic [7:0] r);
    exp_t x;
    bus.en  = e;
    bus.req = r;
    model_edge(e, r);
    x.v   = m_busy;
    x.idx = 3'(m_owner);
    x.oh  = m_busy ? (8'h01 << m_owner) : 8'h00;
    x.to  = m_to;
    sb.push_back(x);
    @(negedge clk);
    #1;
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("grant_valid", 32'(bus.grant_valid), 32'(e.v));
      check("grant_idx", 32'(bus.grant_idx), 32'(e.idx));
      check("grant_onehot", 32'(bus.grant_onehot), 32'(e.oh));
      check("timeout", 32'(bus.timeout), 32'(e.to));
    end
  end

  // Asynchronous reset between edges while a grant is held
  task automatic pulse_reset_midgrant();
    #1;
    check("pre_reset_valid", 32'(bus.grant_valid), 32'(m_busy));
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.grant_valid), 32'd0);
    check("async_rst_onehot", 32'(bus.grant_onehot), 32'd0);
    check("async_rst_timeout", 32'(bus.timeout), 32'd0);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [7:0] r;
    logic       e;
    bit         dropped;
    int         hold_left;

    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.req = 8'h00;
    model_reset();
    #3;
    check("reset_valid", 32'(bus.grant_valid), 32'd0);
    check("reset_idx", 32'(bus.grant_idx), 32'd0);
    check("reset_onehot", 32'(bus.grant_onehot), 32'd0);
    check("reset_timeout", 32'(bus.timeout), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // No requests: nothing granted
    repeat (5) step(1'b1, 8'h00);

    // All requesting: 0..7,0 with MAXH-cycle grants and one dead cycle
    repeat (46) step(1'b1, 8'hFF);
    repeat (2) step(1'b1, 8'h00);

    // Requester 2 releases after three granted cycles
    dropped = 0;
    for (int i = 0; i < 30; i++) begin
      if (!dropped && m_busy && m_owner == 2 && m_held == 3) dropped = 1;
      step(1'b1, dropped ? 8'h20 : 8'h24);
    end
    repeat (2) step(1'b1, 8'h00);

    // Pointer at 6, then 0 and 6 alternate across the wrap
    repeat (3) step(1'b1, 8'h40);
    repeat (2) step(1'b1, 8'h00);
    repeat (20) step(1'b1, 8'h41);
    repeat (2) step(1'b1, 8'h00);

    // Enable gates new grants only
    repeat (5) step(1'b0, 8'h08);
    step(1'b1, 8'h08);
    repeat (3) step(1'b0, 8'h08);
    repeat (2) step(1'b0, 8'h00);

    // Random traffic, requests held for a few cycles at a time
    r = 8'h00;
    e = 1'b1;
    hold_left = 0;
    repeat (300) begin
      if (hold_left == 0) begin
        r = 8'($urandom);
        case ($urandom_range(3))
          0: r = 8'h00;
          1: r = 8'h01 << $urandom_range(7);
          default: ;
        endcase
        e = ($urandom_range(4) != 0);
        hold_left = $urandom_range(8, 1);
      end
      hold_left--;
      step(e, r);
    end
    repeat (2) step(1'b1, 8'h00);

    // Reset in the middle of a grant, then requesters 0 and 7
    repeat (2) step(1'b1, 8'h10);
    pulse_reset_midgrant();
    repeat (6) step(1'b1, 8'h81);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
